// File: rtl/text_ram_arbiter_if.sv
// Bus bundle between the text RAM arbiter and its three clients plus the RAM.
// The master side is the requester/RAM environment; the slave side is the arbiter.
interface text_ram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    // VGA dispatch fetch path
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_valid;
    // Host read/write port
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    // Clear-screen engine control
    logic              clr_start;
    logic [DATA_W-1:0] clr_char;
    logic              clr_busy;
    logic              clr_done;
    // Single RAM port (1-cycle synchronous read)
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output vga_req, vga_addr, input vga_rdata, vga_valid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        output clr_start, clr_char, input clr_busy, clr_done,
        input  ram_addr, ram_we, ram_din, output ram_dout
    );

    modport slave (
        input  vga_req, vga_addr, output vga_rdata, vga_valid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        input  clr_start, clr_char, output clr_busy, clr_done,
        output ram_addr, ram_we, ram_din, input ram_dout
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Time-shares one text/glyph RAM port between VGA fetch (highest priority),
// host accesses and a clear-screen fill engine (lowest priority).
// Every winner is registered onto the RAM port, so reads return two cycles
// after the request cycle.
module text_ram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int CLR_BASE = 0,
    parameter int CLR_LEN  = 4800
) (
    input  logic              clk,
    input  logic              rst_n,
    text_ram_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(CLR_BASE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLR_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              clr_done_q, clr_done_d;
    logic              armed_q;          // blocks clr_start on the first edge after reset release

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;

    logic              host_gnt_q;
    logic              host_rd_q, host_rvalid_q;
    logic              vga_pend_q, vga_valid_q;

    logic              vga_win, host_win, clr_win;

    // Fixed-priority winner selection; host is masked in its grant cycle so a
    // still-held request cannot be accepted twice.
    always_comb begin
        vga_win  = bus.vga_req;
        host_win = bus.host_req && !host_gnt_q && !bus.vga_req;
        clr_win  = (state_q == CLEAR) && !vga_win && !host_win;
    end

    // Clear FSM next state: fill only on slots nobody else wants.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_start && armed_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fill_d  = bus.clr_char;
                end
            end
            CLEAR: begin
                if (clr_win) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST) begin
                        state_d    = IDLE;
                        clr_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port mux: idle cycles keep address/data and only drop the write enable.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        if (vga_win) begin
            ram_addr_d = bus.vga_addr;
        end else if (host_win) begin
            ram_addr_d = bus.host_addr;
            ram_din_d  = bus.host_wdata;
            ram_we_d   = bus.host_we;
        end else if (clr_win) begin
            ram_addr_d = BASE + cnt_q;
            ram_din_d  = fill_q;
            ram_we_d   = 1'b1;
        end
    end

    // Clear FSM state, counter and latched fill word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fill_q     <= '0;
            clr_done_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            clr_done_q <= clr_done_d;
            armed_q    <= 1'b1;
        end
    end

    // Registered RAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
        end
    end

    // Grant pulse and two-stage read-valid pipelines matching the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_gnt_q    <= 1'b0;
            host_rd_q     <= 1'b0;
            host_rvalid_q <= 1'b0;
            vga_pend_q    <= 1'b0;
            vga_valid_q   <= 1'b0;
        end else begin
            host_gnt_q    <= host_win;
            host_rd_q     <= host_win && !bus.host_we;
            host_rvalid_q <= host_rd_q;
            vga_pend_q    <= vga_win;
            vga_valid_q   <= vga_pend_q;
        end
    end

    // Read data is gated by its valid so idle outputs stay at zero.
    assign bus.vga_valid   = vga_valid_q;
    assign bus.vga_rdata   = vga_valid_q ? bus.ram_dout : '0;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rvalid_q ? bus.ram_dout : '0;
    assign bus.clr_busy    = (state_q == CLEAR);
    assign bus.clr_done    = clr_done_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_din     = ram_din_q;
endmodule

// File: tb/tb_text_ram_arbiter.sv
// Self-checking bench for text_ram_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-indexed expectation model and a shadow RAM.
module tb_text_ram_arbiter;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int CLR_BASE = 0;
    localparam int CLR_LEN  = 4800;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    text_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_BASE(CLR_BASE), .CLR_LEN(CLR_LEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] mem     [DEPTH];   // the RAM the arbiter drives
    logic [DW-1:0] ref_mem [DEPTH];   // contents expected from the access rules
    logic          mem_load = 1'b0;
    int checks = 0;
    int failures = 0;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 16) return 16'h4141;
        return DW'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Synchronous single-port RAM, read-first, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    function automatic logic [67:0] all_outs();
        return {bus.vga_rdata, bus.host_rdata, bus.ram_din, bus.ram_addr,
                bus.vga_valid, bus.host_gnt, bus.host_rvalid, bus.clr_busy, bus.clr_done, bus.ram_we};
    endfunction

    task automatic idle_inputs();
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.clr_start = 1'b0; bus.clr_char = '0;
    endtask

    // Leaves the bench at cycle 1 after release (post-edge + 1), RAM reloaded.
    task automatic do_reset(input bit clr_at_release);
        rst_n = 1'b0;
        idle_inputs();
        mem_load = 1'b1;
        @(posedge clk); #1;
        mem_load = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        @(posedge clk); #1;
        bus.clr_start = clr_at_release;
        bus.clr_char  = 16'h0BAD;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        @(negedge clk);
        checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
        checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL reset_release_clr_start: clr_busy got %b want 0", bus.clr_busy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL reset_release_clr_start_late: clr_busy got %b want 0", bus.clr_busy); end
    endtask

    task automatic test_vga_basic();
        do_reset(1'b0);
        bus.vga_req = 1'b1; bus.vga_addr = 14'h0010;
        @(posedge clk); #1;
        bus.vga_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.ram_addr !== 14'h0010) begin failures++; $display("FAIL vga_basic_addr: got %h want 0010", bus.ram_addr); end
        checks++; if (bus.vga_valid !== 1'b0) begin failures++; $display("FAIL vga_basic_early_valid: got %b want 0", bus.vga_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.vga_valid !== 1'b1) begin failures++; $display("FAIL vga_basic_valid: got %b want 1", bus.vga_valid); end
        checks++; if (bus.vga_rdata !== 16'h4141) begin failures++; $display("FAIL vga_basic_data: got %h want 4141", bus.vga_rdata); end
        checks++; if (bus.host_gnt !== 1'b0) begin failures++; $display("FAIL vga_basic_gnt: got %b want 0", bus.host_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.vga_valid !== 1'b0) begin failures++; $display("FAIL vga_basic_valid_end: got %b want 0", bus.vga_valid); end
    endtask

    task automatic test_host_write_read();
        do_reset(1'b0);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 14'h0100; bus.host_wdata = 16'h1234;
        ref_mem[14'h0100] = 16'h1234;
        @(negedge clk);
        checks++; if (bus.host_gnt !== 1'b0) begin failures++; $display("FAIL host_wr_early_gnt: got %b want 0", bus.host_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.host_gnt !== 1'b1) begin failures++; $display("FAIL host_wr_gnt: got %b want 1", bus.host_gnt); end
        checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 14'h0100, 16'h1234})
            begin failures++; $display("FAIL host_wr_port: got we=%b a=%h d=%h want we=1 a=0100 d=1234", bus.ram_we, bus.ram_addr, bus.ram_din); end
        @(posedge clk); #1;
        bus.host_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.host_gnt !== 1'b0 || bus.ram_we !== 1'b0)
            begin failures++; $display("FAIL host_wr_single: gnt=%b we=%b want 0 0", bus.host_gnt, bus.ram_we); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.host_gnt !== 1'b1) begin failures++; $display("FAIL host_rd_gnt: got %b want 1", bus.host_gnt); end
        checks++; if (bus.ram_we !== 1'b0 || bus.host_rvalid !== 1'b0)
            begin failures++; $display("FAIL host_rd_issue: we=%b rvalid=%b want 0 0", bus.ram_we, bus.host_rvalid); end
        @(posedge clk); #1;
        bus.host_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.host_rvalid !== 1'b1) begin failures++; $display("FAIL host_rd_rvalid: got %b want 1", bus.host_rvalid); end
        checks++; if (bus.host_rdata !== 16'h1234) begin failures++; $display("FAIL host_rd_data: got %h want 1234", bus.host_rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.host_rvalid !== 1'b0 || bus.host_gnt !== 1'b0)
            begin failures++; $display("FAIL host_rd_end: rvalid=%b gnt=%b want 0 0", bus.host_rvalid, bus.host_gnt); end
    endtask

    task automatic test_vga_blocks_host();
        logic [AW-1:0] va [10];
        do_reset(1'b0);
        for (int t = 0; t < 10; t++) begin
            va[t] = AW'($urandom);
            bus.vga_req = (t < 6); bus.vga_addr = va[t];
            bus.host_req = (t <= 7); bus.host_we = 1'b0; bus.host_addr = 14'h0200;
            @(negedge clk);
            checks++; if (bus.host_gnt !== (t == 7)) begin failures++; $display("FAIL block_gnt t=%0d: got %b want %b", t, bus.host_gnt, t == 7); end
            checks++; if (bus.vga_valid !== (t >= 2 && t <= 7)) begin failures++; $display("FAIL block_vvalid t=%0d: got %b", t, bus.vga_valid); end
            if (t >= 2 && t <= 7) begin
                checks++; if (bus.vga_rdata !== ref_mem[va[t-2]]) begin failures++; $display("FAIL block_vdata t=%0d: got %h want %h", t, bus.vga_rdata, ref_mem[va[t-2]]); end
            end
            checks++; if (bus.host_rvalid !== (t == 8)) begin failures++; $display("FAIL block_rvalid t=%0d: got %b", t, bus.host_rvalid); end
            if (t == 8) begin
                checks++; if (bus.host_rdata !== ref_mem[14'h0200]) begin failures++; $display("FAIL block_rdata: got %h want %h", bus.host_rdata, ref_mem[14'h0200]); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // Randomized traffic; expectations are indexed by the cycle they must appear in.
    task automatic test_traffic(input string name, input int n, input int vga_pct, input bit vga_every4,
                                input int host_pct, input int host_max, input bit host_rd_only,
                                input int clr_at, input logic [DW-1:0] clr_c,
                                input int clr2_at, input logic [DW-1:0] clr2_c,
                                output int busy_cycles, output int stolen);
        bit e_vv[], e_gnt[], e_rv[], e_we[], e_busy[], e_done[];
        logic [DW-1:0] e_vd[], e_rd[], e_din[];
        logic [AW-1:0] e_addr[];
        int h_state, h_cnt, m_cnt, lfail, bad_at;
        logic h_we; logic [AW-1:0] h_addr, va, cur_addr; logic [DW-1:0] h_wdata, m_fill, cur_din, cchar;
        bit m_busy, was_busy, vga, hwin, cstart;
        e_vv = new[n+4]; e_gnt = new[n+4]; e_rv = new[n+4]; e_we = new[n+4]; e_busy = new[n+4]; e_done = new[n+4];
        e_vd = new[n+4]; e_rd = new[n+4]; e_din = new[n+4]; e_addr = new[n+4];
        for (int i = 0; i < n + 4; i++) begin e_vd[i] = '0; e_rd[i] = '0; e_din[i] = '0; e_addr[i] = '0; end
        do_reset(1'b0);
        h_state = 0; h_cnt = 0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        m_busy = 1'b0; m_cnt = 0; m_fill = '0; cur_addr = '0; cur_din = '0;
        busy_cycles = 0; stolen = 0; lfail = 0;
        for (int t = 0; t < n + 2; t++) begin
            vga = 1'b0; va = AW'($urandom); cstart = 1'b0; cchar = '0;
            if (t < n) begin
                vga = vga_every4 ? (t % 4 == 0) : ($urandom_range(99) < vga_pct);
                if (h_state == 0 && h_cnt < host_max && $urandom_range(99) < host_pct) begin
                    h_state = 1; h_cnt++;
                    h_we = host_rd_only ? 1'b0 : 1'($urandom_range(1));
                    h_addr = AW'(16'h0100 + $urandom_range(7));
                    h_wdata = DW'($urandom);
                end
                if (t == clr_at)  begin cstart = 1'b1; cchar = clr_c;  end
                if (t == clr2_at) begin cstart = 1'b1; cchar = clr2_c; end
            end
            bus.vga_req = vga; bus.vga_addr = va;
            bus.host_req = (h_state != 0); bus.host_we = h_we; bus.host_addr = h_addr; bus.host_wdata = h_wdata;
            bus.clr_start = cstart; bus.clr_char = cchar;
            // Expected effects of this cycle's requests
            was_busy = m_busy;
            e_busy[t] = m_busy;
            hwin = (h_state == 1) && !vga;
            if (vga) begin
                e_vv[t+2] = 1'b1; e_vd[t+2] = ref_mem[va]; cur_addr = va;
            end else if (hwin) begin
                e_gnt[t+1] = 1'b1; cur_addr = h_addr; cur_din = h_wdata; e_we[t+1] = h_we;
                if (h_we) ref_mem[h_addr] = h_wdata;
                else begin e_rv[t+2] = 1'b1; e_rd[t+2] = ref_mem[h_addr]; end
            end else if (was_busy) begin
                cur_addr = AW'(CLR_BASE + m_cnt); cur_din = m_fill; e_we[t+1] = 1'b1;
                ref_mem[cur_addr] = m_fill;
                m_cnt++;
                if (m_cnt == CLR_LEN) begin m_busy = 1'b0; e_done[t+1] = 1'b1; end
            end
            if (was_busy && (vga || hwin)) stolen++;
            e_addr[t+1] = cur_addr; e_din[t+1] = cur_din;
            if (!was_busy && cstart) begin m_busy = 1'b1; m_cnt = 0; m_fill = cchar; end
            if (hwin) h_state = 2; else if (h_state == 2) h_state = 0;
            @(negedge clk);
            if (bus.clr_busy === 1'b1) busy_cycles++;
            checks++; if (bus.vga_valid !== e_vv[t]) begin failures++; lfail++; $display("FAIL %s vga_valid t=%0d: got %b want %b", name, t, bus.vga_valid, e_vv[t]); end
            if (e_vv[t]) begin
                checks++; if (bus.vga_rdata !== e_vd[t]) begin failures++; lfail++; $display("FAIL %s vga_rdata t=%0d: got %h want %h", name, t, bus.vga_rdata, e_vd[t]); end
            end
            checks++; if (bus.host_gnt !== e_gnt[t]) begin failures++; lfail++; $display("FAIL %s host_gnt t=%0d: got %b want %b", name, t, bus.host_gnt, e_gnt[t]); end
            checks++; if (bus.host_rvalid !== e_rv[t]) begin failures++; lfail++; $display("FAIL %s host_rvalid t=%0d: got %b want %b", name, t, bus.host_rvalid, e_rv[t]); end
            if (e_rv[t]) begin
                checks++; if (bus.host_rdata !== e_rd[t]) begin failures++; lfail++; $display("FAIL %s host_rdata t=%0d: got %h want %h", name, t, bus.host_rdata, e_rd[t]); end
            end
            checks++; if (bus.ram_we !== e_we[t]) begin failures++; lfail++; $display("FAIL %s ram_we t=%0d: got %b want %b", name, t, bus.ram_we, e_we[t]); end
            checks++; if (bus.ram_addr !== e_addr[t]) begin failures++; lfail++; $display("FAIL %s ram_addr t=%0d: got %h want %h", name, t, bus.ram_addr, e_addr[t]); end
            if (e_we[t]) begin
                checks++; if (bus.ram_din !== e_din[t]) begin failures++; lfail++; $display("FAIL %s ram_din t=%0d: got %h want %h", name, t, bus.ram_din, e_din[t]); end
            end
            checks++; if (bus.clr_busy !== e_busy[t]) begin failures++; lfail++; $display("FAIL %s clr_busy t=%0d: got %b want %b", name, t, bus.clr_busy, e_busy[t]); end
            checks++; if (bus.clr_done !== e_done[t]) begin failures++; lfail++; $display("FAIL %s clr_done t=%0d: got %b want %b", name, t, bus.clr_done, e_done[t]); end
            @(posedge clk); #1;
            if (lfail >= 20) break;
        end
        idle_inputs();
        bad_at = -1;
        for (int i = 0; i < DEPTH; i++) if (bad_at < 0 && mem[i] !== ref_mem[i]) bad_at = i;
        checks++; if (bad_at >= 0) begin failures++; $display("FAIL %s ram_contents addr=%0h: got %h want %h", name, bad_at, mem[bad_at], ref_mem[bad_at]); end
    endtask

    task automatic test_mixed_traffic();
        int b, s;
        test_traffic("vga_back_to_back", 40, 100, 1'b0, 0, 0, 1'b0, -1, '0, -1, '0, b, s);
        test_traffic("host_only", 200, 0, 1'b0, 80, 1000, 1'b0, -1, '0, -1, '0, b, s);
        test_traffic("mixed", 400, 40, 1'b0, 60, 1000, 1'b0, -1, '0, -1, '0, b, s);
    endtask

    task automatic test_clear_full();
        int b, s;
        test_traffic("clear_full", 4806, 0, 1'b0, 0, 0, 1'b0, 0, 16'h0020, -1, '0, b, s);
        checks++; if (b !== CLR_LEN) begin failures++; $display("FAIL clear_full_busy_len: got %0d want %0d", b, CLR_LEN); end
        checks++; if (mem[4799] !== 16'h0020) begin failures++; $display("FAIL clear_full_last: got %h want 0020", mem[4799]); end
        checks++; if (mem[4800] !== init_val(4800)) begin failures++; $display("FAIL clear_full_beyond: got %h want %h", mem[4800], init_val(4800)); end
    endtask

    task automatic test_clear_traffic();
        int b, s;
        test_traffic("clear_traffic", 6700, 0, 1'b1, 2, 1, 1'b1, 3, 16'h0020, 2000, 16'h0055, b, s);
        checks++; if (b !== CLR_LEN + s) begin failures++; $display("FAIL clear_traffic_busy_len: got %0d want %0d", b, CLR_LEN + s); end
        checks++; if (mem[2500] !== 16'h0020) begin failures++; $display("FAIL clear_traffic_restart_char: got %h want 0020", mem[2500]); end
    endtask

    task automatic test_clear_reset();
        do_reset(1'b0);
        bus.clr_start = 1'b1; bus.clr_char = 16'h0020;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.clr_busy !== 1'b1 || bus.ram_addr !== AW'(CLR_BASE + 99))
            begin failures++; $display("FAIL clr_rst_progress: busy=%b addr=%h want 1 %h", bus.clr_busy, bus.ram_addr, AW'(CLR_BASE + 99)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (all_outs() !== '0) begin failures++; $display("FAIL clr_rst_async: got %h want 0", all_outs()); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0)
                begin failures++; $display("FAIL clr_rst_after i=%0d: done=%b busy=%b want 0 0", i, bus.clr_done, bus.clr_busy); end
            @(posedge clk); #1;
        end
        bus.clr_start = 1'b1; bus.clr_char = 16'h0777;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, AW'(CLR_BASE), 16'h0777})
            begin failures++; $display("FAIL clr_rst_restart: we=%b a=%h d=%h want 1 %h 0777", bus.ram_we, bus.ram_addr, bus.ram_din, AW'(CLR_BASE)); end
        rst_n = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_vga_basic();
        test_host_write_read();
        test_vga_blocks_host();
        test_mixed_traffic();
        test_clear_full();
        test_clear_traffic();
        test_clear_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Time-shares the text/glyph RAM port between three requesters:
  - the VGA dispatch fetch path (hard real-time, highest priority);
  - a host read/write port (character updates from the CPU side);
  - a built-in clear-screen fill engine (lowest priority).
- Sits between VGA_Dispatch/host logic and the ram block, and drives addra/wea/dina/douta in place of a direct dispatch connection.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 16, RAM data width.
- CLR_BASE, 0, first word address written by the clear engine.
- CLR_LEN, 4800, number of words written per clear (80x60 character cells).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- vga_req  in  1  dispatch fetch request, single-cycle, no handshake
- vga_addr  in  ADDR_W  dispatch fetch address
- vga_rdata  out  DATA_W  fetched word
- vga_valid  out  1  vga_rdata valid
- host_req  in  1  host access request, held until host_gnt
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  one-cycle accept pulse
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid (reads only)
- clr_start  in  1  start-clear pulse
- clr_char  in  DATA_W  fill word, sampled at clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear finishes
- ram_addr  out  ADDR_W  to RAM addra
- ram_we  out  1  to RAM wea
- ram_din  out  DATA_W  to RAM dina
- ram_dout  in  DATA_W  from RAM douta (1-cycle synchronous read)

Behaviour:
Reset:
- All outputs 0, FSM in IDLE, clear counter 0, latched fill word 0.
- Reset mid-clear aborts the fill; no clr_done is produced, and in-flight valids are dropped.

Arbitration (cycle N):
- Priority is vga_req > host_req (masked while host_gnt=1) > clear engine.
- The winner's addr/we/din is registered onto ram_* at the end of N.
- Cycles with no winner: ram_we=0; ram_addr and ram_din hold their previous values.

Latency:
- VGA: vga_valid=1 and vga_rdata=ram_dout in cycle N+2. The path is fully pipelined, so back-to-back vga_req yields back-to-back valids.
- Host: host_gnt=1 in cycle N+1.
  - Read: host_rvalid=1 with data in N+2.
  - Write: no rvalid; the RAM is written at the N+1 edge.
- Host must hold its request fields stable until it sees host_gnt. It may re-assert host_req in the cycle after host_gnt. Max host throughput is one access per 2 cycles.
- Host starvation under continuous vga_req is permitted; dispatch idle slots (blanking) guarantee progress.

Clear FSM, states IDLE and CLEAR:
- IDLE -> CLEAR on clr_start:
  - latch clr_char;
  - counter := 0;
  - clr_busy=1 from the next cycle.
- In CLEAR:
  - each cycle with no vga or host winner issues a write of the latched word to (CLR_BASE+counter) mod 2^ADDR_W;
  - the counter increments on each issued write.
- CLEAR -> IDLE in the cycle after the write with counter=CLR_LEN-1 is issued. In that cycle clr_done=1 and clr_busy=0.
- clr_start while busy is ignored; it does not restart and does not re-latch clr_char.
- clr_start coincident with reset release is ignored.
- Host writes during CLEAR are serviced. A host write may later be overwritten by the clear if its address has not yet been cleared (documented, not prevented).
- The counter is ADDR_W bits. CLR_LEN=0 is illegal.

Simultaneous events:
- vga_req and host_req in the same cycle: VGA wins; host is granted in the first cycle without vga_req.
- The RAM is never written twice in one cycle. Exactly one source drives ram_* per cycle.

Test Plan:
- Reset, then vga_req@addr 0x0010 with RAM[0x10]=0x4141: ram_addr=0x0010 one cycle later, vga_valid=1 with vga_rdata=0x4141 exactly 2 cycles after request; no host_gnt.
- Host write 0x1234@0x0100, then host read 0x0100: host_gnt pulses once per access; read returns host_rvalid=1, host_rdata=0x1234 two cycles after its request cycle; ram_we=1 only in the write-issue cycle.
- vga_req held high 6 cycles while host_req read 0x0200 is pending: no host_gnt during those cycles; host_gnt in the first cycle after vga_req drops +1; 6 consecutive vga_valid.
- clr_start with clr_char=0x0020, CLR_BASE=0, CLR_LEN=4800, no other traffic: clr_busy high exactly 4800 cycles, writes to 0..4799 in order, one clr_done pulse, RAM[4799]=0x0020, RAM[4800] unchanged.
- During clear, interleave vga_req every 4th cycle and one host read: clear writes skip those slots, clear takes 4800+stolen cycles, second clr_start mid-clear ignored (clr_char change not applied).
- Assert rst_n=0 at counter=100 of a clear: all outputs 0 immediately (async); after release, no clr_done; a new clr_start restarts from CLR_BASE.
